// File: rtl/fpu_div_pkg.sv
// ---------------------------------------------------------------------------
// fpu_div_pkg
// Shared definitions for the sequential mantissa divider of the FPU divide
// path: default widths, controller state encoding and the iteration counter
// width helper.
// ---------------------------------------------------------------------------
package fpu_div_pkg;

    // Mantissa width including the hidden bit, and raw quotient width.
    localparam int MANT_W_DEF = 24;
    localparam int QUOT_W_DEF = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter walks MANT_W down to 0 inclusive, so it must hold MANT_W.
    function automatic int cnt_width(input int mant_w);
        return $clog2(mant_w + 1);
    endfunction

endpackage

// File: rtl/fpu_mantissa_divider_seq_if.sv
// ---------------------------------------------------------------------------
// fpu_mantissa_divider_seq_if
// Request/result bundle of the sequential mantissa divider.
//   master : drives start and the two operand mantissas, observes results
//   slave  : the divider itself
// Signals:
//   start          request, taken only when the divider is ready
//   mantissa_num1  dividend mantissa (hidden bit included)
//   mantissa_num2  divisor mantissa (hidden bit included)
//   busy           operation in flight
//   done           one-cycle pulse, results valid
//   quotient       floor((num1 << MANT_W) / num2), zero-extended
//   remainder      (num1 << MANT_W) - quotient * num2
//   div_by_zero    num2 was zero for the last operation
//   range_err      num1 >= 2 * num2 for the last operation
// ---------------------------------------------------------------------------
interface fpu_mantissa_divider_seq_if
    import fpu_div_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int QUOT_W = QUOT_W_DEF
);

    logic              start;
    logic [MANT_W-1:0] mantissa_num1;
    logic [MANT_W-1:0] mantissa_num2;
    logic              busy;
    logic              done;
    logic [QUOT_W-1:0] quotient;
    logic [MANT_W-1:0] remainder;
    logic              div_by_zero;
    logic              range_err;

    modport master (
        output start, mantissa_num1, mantissa_num2,
        input  busy, done, quotient, remainder, div_by_zero, range_err
    );

    modport slave (
        input  start, mantissa_num1, mantissa_num2,
        output busy, done, quotient, remainder, div_by_zero, range_err
    );

endinterface

// File: rtl/fpu_div_step.sv
// ---------------------------------------------------------------------------
// fpu_div_step
// One restoring-division iteration: compare the partial remainder with the
// divisor, subtract when it fits, then shift left for the next bit unless
// this is the last iteration.
// Ports:
//   r        partial remainder, MANT_W+1 bits (always < 2 * divisor)
//   divisor  divisor mantissa
//   last     final iteration, suppresses the shift
//   q_bit    quotient bit produced by this iteration
//   r_next   partial remainder for the next iteration (or the final one)
// ---------------------------------------------------------------------------
module fpu_div_step #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W:0]   r,
    input  logic [MANT_W-1:0] divisor,
    input  logic              last,
    output logic              q_bit,
    output logic [MANT_W:0]   r_next
);

    logic [MANT_W:0] div_ext;
    logic [MANT_W:0] restored;

    assign div_ext = {1'b0, divisor};

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave a value held (no latch inferred).
    always_comb begin
        q_bit    = 1'b0;
        restored = r;
        if (r >= div_ext) begin
            q_bit    = 1'b1;
            restored = r - div_ext;
        end
        // After a subtract the value is below the divisor, so doubling it
        // still fits in MANT_W+1 bits.
        r_next = last ? restored : {restored[MANT_W-1:0], 1'b0};
    end

endmodule

// File: rtl/fpu_mantissa_divider_seq.sv
// ---------------------------------------------------------------------------
// fpu_mantissa_divider_seq
// Radix-2 restoring divider for the single-precision divide path. Produces
// one quotient bit per clock: MANT_W+1 iterations after an accepted start,
// then a one-cycle done pulse. Zero or unnormalized divisors are flagged
// and finish on the cycle after accept with a zero result.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    request/result bundle (slave side), see the interface file
// ---------------------------------------------------------------------------
module fpu_mantissa_divider_seq
    import fpu_div_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int QUOT_W = QUOT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fpu_mantissa_divider_seq_if.slave  bus
);

    localparam int CNT_W = cnt_width(MANT_W);

    state_t            state;
    logic [MANT_W:0]   rem_work;     // partial remainder
    logic [MANT_W-1:0] divisor_r;    // divisor captured at accept
    logic [CNT_W-1:0]  count_r;      // bit index of the current iteration

    logic              busy_r;
    logic              done_r;
    logic [QUOT_W-1:0] quot_r;
    logic [MANT_W-1:0] rem_r;
    logic              dz_r;
    logic              re_r;

    logic              q_bit;
    logic [MANT_W:0]   rem_next;
    logic              last_iter;
    logic              num2_zero;
    logic              num2_unnorm;

    assign last_iter   = (count_r == '0);
    assign num2_zero   = (bus.mantissa_num2 == '0);
    // num1 >= 2*num2 would need more than MANT_W+1 quotient bits.
    assign num2_unnorm = ({1'b0, bus.mantissa_num1} >= {bus.mantissa_num2, 1'b0});

    fpu_div_step #(.MANT_W(MANT_W)) u_step (
        .r       (rem_work),
        .divisor (divisor_r),
        .last    (last_iter),
        .q_bit   (q_bit),
        .r_next  (rem_next)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: every register, result registers included, is cleared by the
    // asynchronous reset because the outputs must read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem_work  <= '0;
            divisor_r <= '0;
            count_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            quot_r    <= '0;
            rem_r     <= '0;
            dz_r      <= 1'b0;
            re_r      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
                        quot_r <= '0;
                        rem_r  <= '0;
                        if (num2_zero) begin
                            dz_r   <= 1'b1;
                            re_r   <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else if (num2_unnorm) begin
                            dz_r   <= 1'b0;
                            re_r   <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            dz_r      <= 1'b0;
                            re_r      <= 1'b0;
                            rem_work  <= {1'b0, bus.mantissa_num1};
                            divisor_r <= bus.mantissa_num2;
                            count_r   <= CNT_W'(MANT_W);
                            busy_r    <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end

                RUN: begin
                    // Bits enter at the LSB; after MANT_W+1 shifts the first
                    // bit sits at index MANT_W and the upper bits stay zero.
                    quot_r   <= {quot_r[QUOT_W-2:0], q_bit};
                    rem_work <= rem_next;
                    count_r  <= count_r - CNT_W'(1);
                    if (last_iter) begin
                        rem_r  <= rem_next[MANT_W-1:0];
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
    assign bus.range_err   = re_r;

endmodule
